// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int unsigned DEF_PRESCALE_W = 6;
  localparam int unsigned DEF_BIT_CNT_W  = 4;

  // Bit positions within a frame
  localparam int unsigned BIT_START      = 0;
  localparam int unsigned BIT_DATA_FIRST = 1;
  localparam int unsigned BIT_DATA_LAST  = 8;
  localparam int unsigned BIT_PAR        = 9;
  localparam int unsigned BIT_STP_NOPAR  = 9;
  localparam int unsigned BIT_STP_PAR    = 10;

  // Supported oversampling ratios
  localparam int unsigned PRESCALE_4  = 4;
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Two-of-three vote over the mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversampling edge counter and saturating bit counter for the UART receiver.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = DEF_BIT_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic [PRESCALE_W-1:0] last_edge;

  // Final edge index of a bit; prescale of 0 behaves as 1
  always_comb begin
    last_edge = '0;
    if (prescale != '0)
      last_edge = prescale - PRESCALE_W'(1);
  end

  // Advance edge index, roll into bit index, saturate bit index at all-ones
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == last_edge) begin
      edge_cnt <= '0;
      if (bit_cnt != '1)
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rx_bit_sampler.sv
// UART receive timing stage: edge/bit counters plus three-point mid-bit
// majority sampler with a one-cycle valid strobe.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = DEF_BIT_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  input  logic                  data_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  samp_valid
);

  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] samp_lo;
  logic [PRESCALE_W-1:0] samp_hi;
  logic                  samp_ok;
  logic                  s0;
  logic                  s1;

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Sample indices around mid-bit; sampling only for even prescale >= 4
  always_comb begin
    mid     = prescale >> 1;
    samp_lo = mid - PRESCALE_W'(1);
    samp_hi = mid + PRESCALE_W'(1);
    samp_ok = (prescale >= PRESCALE_W'(PRESCALE_4)) && !prescale[0];
  end

  // Capture two early samples, vote with the third and strobe the result
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
      samp_valid  <= 1'b0;
    end else begin
      samp_valid <= 1'b0;
      if (data_samp_en && samp_ok) begin
        if (edge_cnt == samp_lo) begin
          s0 <= RX_IN;
        end else if (edge_cnt == mid) begin
          s1 <= RX_IN;
        end else if (edge_cnt == samp_hi) begin
          sampled_bit <= majority3(s0, s1, RX_IN);
          samp_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Scoreboard bench for rx_bit_sampler: stimulus pushes expected per-cycle
// outputs and expected voted bits; a monitor pops and compares.
module tb_rx_bit_sampler;
  import uart_rx_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       enable;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  typedef struct {
    int e;
    int b;
    int v;
    int s;
  } exp_t;

  exp_t cyc_q[$];
  logic bit_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   sv_count = 0;
  logic cur_sb   = 1'b1;

  rx_bit_sampler #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .enable       (enable),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .samp_valid   (samp_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare after each active edge
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (cyc_q.size() > 0) begin
        x = cyc_q.pop_front();
        chk("edge_cnt", int'(edge_cnt), x.e);
        chk("bit_cnt", int'(bit_cnt), x.b);
        chk("samp_valid", int'(samp_valid), x.v);
        chk("sampled_bit", int'(sampled_bit), x.s);
      end
      if (samp_valid) begin
        sv_count++;
        if (bit_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          chk("voted_bit", int'(sampled_bit), int'(bit_q.pop_front()));
        end
      end
    end
  end

  // Drive one cycle of inputs and record outputs expected after the next edge
  task automatic cyc(input logic rst, input logic en, input logic dse, input logic rx,
                     input int p, input int e, input int b, input int v, input int s);
    exp_t x;
    @(negedge CLK);
    RST          = rst;
    enable       = en;
    data_samp_en = dse;
    RX_IN        = rx;
    prescale     = 6'(p);
    x.e = e; x.b = b; x.v = v; x.s = s;
    cyc_q.push_back(x);
  endtask

  task automatic clr(input int p);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, p, 0, 0, 0, int'(cur_sb));
  endtask

  // One full bit period with RX_IN taken from rxv indexed by edge
  task automatic bit_period(input int p, input logic [63:0] rxv, input int bidx, input logic expb);
    bit_q.push_back(expb);
    for (int k = 0; k < p; k++) begin
      if (k == p / 2 + 1) cur_sb = expb;
      cyc(1'b1, 1'b1, 1'b1, rxv[k], p, (k + 1) % p,
          (k + 1 == p) ? bidx + 1 : bidx, (k == p / 2 + 1) ? 1 : 0, int'(cur_sb));
    end
  endtask

  initial begin
    int frame_bits[11];
    int sv_base;
    logic [63:0] rxv;
    frame_bits = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
    RST = 1'b0; enable = 1'b1; data_samp_en = 1'b0; RX_IN = 1'b0; prescale = 6'd8;

    // Reset held with enable and RX_IN low
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8, 0, 0, 0, 1);

    // Counter wrap, prescale 8
    for (int k = 0; k < 24; k++)
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8, (k + 1) % 8, (k + 1) / 8, 0, 1);
    clr(8);

    // Solid zero bit, prescale 16
    bit_period(16, 64'h0, 0, 1'b0);
    clr(16);
    // Single-edge glitch rejected
    bit_period(16, 64'hFFFF_FFFF_FFFF_FEFF, 0, 1'b1);
    clr(16);
    // Two of three low wins
    bit_period(16, 64'hFFFF_FFFF_FFFF_FD7F, 0, 1'b0);
    clr(8);

    // Full frame 0x5A with even parity, prescale 8
    sv_base = sv_count;
    for (int i = 0; i < 11; i++) begin
      rxv = (frame_bits[i] != 0) ? '1 : '0;
      bit_period(8, rxv, i, frame_bits[i] != 0);
    end
    clr(4);
    chk("frame_strobes", sv_count - sv_base, 11);

    // Saturation at 15 with prescale 4
    for (int k = 0; k < 80; k++)
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 4, (k + 1) % 4, ((k + 1) / 4 > 15) ? 15 : (k + 1) / 4, 0, int'(cur_sb));
    clr(5);

    // Odd prescale: counters wrap at 4, no sampling
    for (int k = 0; k < 15; k++)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 5, (k + 1) % 5, (k + 1) / 5, 0, int'(cur_sb));
    clr(0);

    // Prescale 0 acts as 1
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, k + 1, 0, int'(cur_sb));
    clr(8);

    // Reset just before the vote point leaves no strobe
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8, k + 1, 0, 0, int'(cur_sb));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8, 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8, 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8, 0, 0, 0, 1);
    @(negedge CLK);

    chk("pending_bits", bit_q.size(), 0);
    chk("pending_cycles", cyc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
- Upstream timing and sampling stage for the UART receive controller FSM.
- Counts oversampling edges (edge_cnt) and bit positions (bit_cnt) within a frame, and produces these counters for the controller.
- Takes three majority-voted samples of RX_IN around mid-bit and drives a registered sampled_bit plus a one-cycle samp_valid strobe.
- Consumers: the start, parity and stop checkers and the deserializer.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt
BIT_CNT_W, 4, width of bit_cnt

Ports:
CLK  in  1  receiver oversampling clock
RST  in  1  synchronous active-low reset
RX_IN  in  1  serial line, idle high (already synchronized)
prescale  in  PRESCALE_W  oversampling ratio; legal values 4, 8, 16, 32
enable  in  1  counter enable from the controller FSM
data_samp_en  in  1  sampling enable from the controller FSM
edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..prescale-1
bit_cnt  out  BIT_CNT_W  bit index in the frame: 0 start, 1-8 data, 9 parity/stop, 10 stop
sampled_bit  out  1  majority-voted value of the current bit
samp_valid  out  1  one-cycle strobe: sampled_bit updated this cycle

Behaviour:
- One clock: CLK. Reset is synchronous and active-low: RST sampled low at a rising CLK edge gives edge_cnt=0, bit_cnt=0, sampled_bit=1, samp_valid=0, and clears internal sample registers s0/s1 to 1.
- Reset mid-frame aborts the frame immediately. There is no residual strobe.
- Counter, for enable=1, evaluated at each CLK edge:
  - edge_cnt != prescale-1: edge_cnt+1.
  - edge_cnt == prescale-1: edge_cnt <- 0 and bit_cnt+1.
  - bit_cnt saturates at 15; it never wraps to 0 while enable is held.
- enable=0: edge_cnt <- 0 and bit_cnt <- 0 on the next edge, regardless of data_samp_en. This is the only non-reset clear.
- Edge 0 of the start bit is the first cycle enable is high. The controller raises enable combinationally in the cycle RX_IN falls.
- Sample points are mid = prescale>>1, giving indices mid-1, mid and mid+1. Comparisons are at PRESCALE_W width; there is no arithmetic overflow for legal prescale.
- With data_samp_en=1:
  - edge_cnt == mid-1: s0 <- RX_IN.
  - edge_cnt == mid: s1 <- RX_IN.
  - edge_cnt == mid+1: sampled_bit <- majority(s0, s1, RX_IN), and samp_valid <- 1 for exactly the following cycle.
- Latency: sampled_bit is valid from edge_cnt == mid+2 of the same bit and holds until the next update.
- data_samp_en=0: s0, s1 and sampled_bit hold their values, and samp_valid=0.
- If data_samp_en drops between sample points, the partial samples are kept. A later update uses whatever s0/s1 last captured.
- Illegal prescale (<4 or odd): counters still run, modulo prescale. samp_valid stays 0, and sampled_bit holds.
- prescale=0 is treated as 1: edge_cnt stays 0 and bit_cnt increments every cycle.
- A prescale change mid-frame takes effect on the next comparison; the result is undefined for the frame in progress. The bench does not check it.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package uart_rx_pkg:
  - PRESCALE_W and BIT_CNT_W defaults.
  - Bit-index constants: BIT_START=0, BIT_DATA_FIRST=1, BIT_DATA_LAST=8, BIT_PAR=9, BIT_STP_NOPAR=9, BIT_STP_PAR=10.
  - Legal prescale constants 4, 8, 16, 32.
- The controller FSM imports the same constants.
- One sub-module, rx_edge_bit_counter, holds the edge/bit counters, enable clear and saturation.
- The top level adds the three-point sampler and majority vote.

Test Plan:
- Reset: hold RST=0 for 3 cycles with enable=1 and RX_IN=0 -> edge_cnt=0, bit_cnt=0, sampled_bit=1, samp_valid=0 throughout.
- Counter wrap: prescale=8, enable=1 for 24 cycles -> edge_cnt 0..7 three times; bit_cnt 0,1,2 changes exactly at the edge_cnt 7->0 wrap. Drop enable -> both are 0 on the next cycle.
- Sampling: prescale=16, RX_IN=0 for a whole bit -> samples at edge_cnt 7/8/9; samp_valid high only when edge_cnt=10; sampled_bit=0.
- Glitch rejection: prescale=16, RX_IN=1 except a single 0 at edge_cnt=8 -> sampled_bit=1. Then 0 at both 7 and 9 -> sampled_bit=0.
- Full frame: prescale=8, frame 0x5A LSB-first with parity, enable held for 11 bits -> samp_valid pulses 11 times; sampled_bit sequence 0,0,1,0,1,1,0,1,0,p,1; bit_cnt reaches 10.
- Saturation and illegal values: prescale=4 with enable held 80 cycles -> bit_cnt stops at 15. Then prescale=5 -> edge_cnt wraps at 4 and samp_valid never asserts.
